// File: rtl/comp_mag_seq_if.sv
// rtl/comp_mag_seq_if.sv - start/result bundle for the sequential magnitude comparator
interface comp_mag_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic         gt;
  logic         eq;
  logic         lt;

  modport master (
    output start, sgn, a, b,
    input  ready, done, gt, eq, lt
  );

  modport slave (
    input  start, sgn, a, b,
    output ready, done, gt, eq, lt
  );
endinterface

// File: rtl/comp_mag_seq.sv
// rtl/comp_mag_seq.sv - MSB-first digit-serial magnitude comparator with early exit
module comp_mag_seq #(
  parameter int W     = 16,
  parameter int DIGIT = 2
) (
  input  logic           clk,
  input  logic           reset,
  comp_mag_seq_if.slave  bus
);
  localparam int           NDIG     = W / DIGIT;
  localparam int           IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
  localparam logic [W-1:0]  MSB_MASK = W'(1) << (W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          next_state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [IW-1:0]   idx;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic            gt_r;
  logic            eq_r;
  logic            lt_r;
  logic            accept;

  assign accept = bus.start && (state == IDLE);
  assign a_dig  = a_r[int'(idx) * DIGIT +: DIGIT];
  assign b_dig  = b_r[int'(idx) * DIGIT +: DIGIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = RUN;
      RUN:  if ((a_dig != b_dig) || (idx == '0)) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE:    bus.ready = 1'b1;
      DONE:    bus.done  = 1'b1;
      default: ;
    endcase
  end

  // Flipping the MSB maps two's complement onto offset binary, so one unsigned digit compare serves both modes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r  <= '0;
      b_r  <= '0;
      idx  <= '0;
      gt_r <= 1'b0;
      eq_r <= 1'b0;
      lt_r <= 1'b0;
    end else if (accept) begin
      a_r  <= bus.a ^ (bus.sgn ? MSB_MASK : '0);
      b_r  <= bus.b ^ (bus.sgn ? MSB_MASK : '0);
      idx  <= LAST_IDX;
      gt_r <= 1'b0;
      eq_r <= 1'b0;
      lt_r <= 1'b0;
    end else if (state == RUN) begin
      if (a_dig > b_dig)      gt_r <= 1'b1;
      else if (a_dig < b_dig) lt_r <= 1'b1;
      else if (idx == '0)     eq_r <= 1'b1;
      else                    idx  <= idx - 1'b1;
    end
  end

  assign bus.gt = gt_r;
  assign bus.eq = eq_r;
  assign bus.lt = lt_r;
endmodule

// File: tb/tb_comp_mag_seq.sv
// tb/tb_comp_mag_seq.sv - randomized self-checking bench for comp_mag_seq (W=8, DIGIT=2)
module tb_comp_mag_seq;
  localparam int W     = 8;
  localparam int DIGIT = 2;
  localparam int NDIG  = W / DIGIT;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  comp_mag_seq_if #(.W(W)) bus ();

  comp_mag_seq #(.W(W), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected {gt,eq,lt} from plain signed/unsigned arithmetic.
  function automatic logic [2:0] model_flags(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    int x, y;
    if (s) begin
      x = $signed(av);
      y = $signed(bv);
    end else begin
      x = av;
      y = bv;
    end
    return {x > y, x == y, x < y};
  endfunction

  // Done cycle: one more than the number of digits examined, found from the highest differing bit.
  function automatic int model_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] diff;
    int hb;
    diff = av ^ bv;
    if (diff == '0) return NDIG + 1;
    hb = 0;
    for (int i = 0; i < W; i++) if (diff[i]) hb = i;
    return NDIG - hb / DIGIT + 1;
  endfunction

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Starts at a negedge; ends at the negedge of the done cycle (or after the budget).
  task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                        output int lat, output logic [2:0] flags);
    logic ok;
    wait_ready(ok);
    lat   = -1;
    flags = 3'bxxx;
    bus.a = av;
    bus.b = bv;
    bus.sgn = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.sgn = 1'($urandom);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat   = c;
        flags = {bus.gt, bus.eq, bus.lt};
        break;
      end
      checks++;
      if ({bus.gt, bus.eq, bus.lt} !== 3'b000) begin
        fails++;
        $display("FAIL run_flags_zero: got %b want 000 in cycle %0d", {bus.gt, bus.eq, bus.lt}, c);
      end
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ready, bus.done, bus.gt, bus.eq, bus.lt} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_state: got rdy/done/gt/eq/lt=%b want 10000", {bus.ready, bus.done, bus.gt, bus.eq, bus.lt});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [W-1:0] av [6] = '{8'hA5, 8'h5A, 8'h12, 8'h80, 8'h80, 8'h00};
    logic [W-1:0] bv [6] = '{8'h35, 8'h5A, 8'h13, 8'h01, 8'h01, 8'h00};
    logic         sv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]   ef [6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b100, 3'b010};
    int           el [6] = '{2, 5, 5, 2, 2, 5};
    int lat;
    logic [2:0] flags;
    for (int i = 0; i < 6; i++) begin
      do_cmp(av[i], bv[i], sv[i], lat, flags);
      checks++;
      if (flags !== ef[i]) begin
        fails++;
        $display("FAIL directed_flags[%0d]: got %b want %b", i, flags, ef[i]);
      end
      checks++;
      if (lat != el[i]) begin
        fails++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, el[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic ok;
    int lat;
    wait_ready(ok);
    bus.a = 8'h12; bus.b = 8'h13; bus.sgn = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'h00; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 5 || {bus.gt, bus.eq, bus.lt} !== 3'b001) begin
      fails++;
      $display("FAIL ignore_start: got lat=%0d flags=%b want lat=5 flags=001", lat, {bus.gt, bus.eq, bus.lt});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || {bus.gt, bus.eq, bus.lt} !== 3'b001) begin
      fails++;
      $display("FAIL ignore_start_idle: got ready=%b flags=%b want ready=1 flags=001", bus.ready, {bus.gt, bus.eq, bus.lt});
    end
  endtask

  task automatic test_reset_mid_run;
    logic ok;
    logic saw_done;
    wait_ready(ok);
    bus.a = 8'h5A; bus.b = 8'h5A; bus.sgn = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.ready, bus.done, bus.gt, bus.eq, bus.lt} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_mid_run: got rdy/done/gt/eq/lt=%b want 10000", {bus.ready, bus.done, bus.gt, bus.eq, bus.lt});
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_no_done: got done_seen=%b ready=%b want 0/1", saw_done, bus.ready);
    end
  endtask

  task automatic test_back_to_back;
    logic ok;
    logic [W-1:0] av, bv;
    logic s;
    int since, seen;
    wait_ready(ok);
    av = W'($urandom); bv = W'($urandom); s = 1'($urandom);
    bus.a = av; bus.b = bv; bus.sgn = s; bus.start = 1'b1;
    since = 0;
    seen  = 0;
    for (int c = 0; c < 60 && seen < 3; c++) begin
      @(posedge clk);
      since++;
      @(negedge clk);
      if (bus.done === 1'b1) begin
        checks++;
        if ({bus.gt, bus.eq, bus.lt} !== model_flags(av, bv, s) || since != model_lat(av, bv)) begin
          fails++;
          $display("FAIL b2b_result[%0d]: got flags=%b lat=%0d want flags=%b lat=%0d",
                   seen, {bus.gt, bus.eq, bus.lt}, since, model_flags(av, bv, s), model_lat(av, bv));
        end
        seen++;
        av = W'($urandom); bv = W'($urandom); s = 1'($urandom);
        if (seen == 2) bv = av;
        bus.a = av; bus.b = bv; bus.sgn = s;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_idle_after_done[%0d]: got ready=%b want 1", seen, bus.ready);
        end
        since = 0;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (seen != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d want 3", seen);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] av, bv;
    logic s;
    int lat;
    logic [2:0] flags;
    int bad;
    for (int i = 0; i < 1000; i++) begin
      av = W'($urandom);
      case ($urandom_range(3, 0))
        0:       bv = av;
        1:       bv = av ^ W'(1 << $urandom_range(W - 1, 0));
        default: bv = W'($urandom);
      endcase
      s = 1'($urandom);
      do_cmp(av, bv, s, lat, flags);
      checks++;
      if (flags !== model_flags(av, bv, s) || lat != model_lat(av, bv)) begin
        fails++;
        bad++;
        if (bad < 10)
          $display("FAIL random[%0d] a=%h b=%h sgn=%b: got flags=%b lat=%0d want flags=%b lat=%0d",
                   i, av, bv, s, flags, lat, model_flags(av, bv, s), model_lat(av, bv));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
